sd_spi_writer: RTL and testbench

//  SPI-mode SD card single-block writer for the data logger: on start, sends CMD24,

---
 rtl/sd_spi_writer.sv | 197 +++++++++++++++++++
 tb/tb_sd_spi_writer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sd_spi_writer.sv
// SPI-mode SD single-block writer: CMD24, R1, token, one 16-bit sample,
// dummy CRC, data-response check and card-busy wait.
module sd_spi_writer #(
  parameter int          CLK_DIV      = 4,
  parameter logic [31:0] BLOCK_ADDR   = 32'h0,
  parameter int          R1_TIMEOUT   = 8,
  parameter int          BUSY_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] data_in,
  output logic        busy,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic        cs
);

  localparam int HALF = CLK_DIV / 2;
  localparam int CW   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int PW   = 16;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_R1,
    S_TOKEN,
    S_DATA,
    S_CRC,
    S_DRESP,
    S_BUSYW,
    S_FIN
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   cnt_q;
  logic [5:0]      bit_left_q;
  logic [PW-1:0]   poll_q;
  logic [47:0]     tx_q;
  logic [7:0]      rx_q;
  logic [15:0]     data_q;
  logic            sclk_q;
  logic            cs_q;
  logic            busy_q;

  logic            shifting;
  logic            rise;
  logic            bit_end;
  logic            seg_end;
  logic            r1_last;
  logic            bw_last;
  logic [47:0]     tx_load;
  logic [5:0]      bits_load;

  assign shifting = (state_q != S_IDLE) && (state_q != S_FIN);
  assign rise     = shifting && (cnt_q == CW'(HALF - 1));
  assign bit_end  = shifting && (cnt_q == CW'(CLK_DIV - 1));
  assign seg_end  = bit_end && (bit_left_q == 6'd0);
  assign r1_last  = (poll_q == PW'(R1_TIMEOUT - 1));
  assign bw_last  = (poll_q == PW'(BUSY_TIMEOUT - 1));

  assign busy = busy_q;
  assign cs   = cs_q;
  assign sclk = sclk_q;
  assign mosi = tx_q[47];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // rx_q holds the complete byte when seg_end fires
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CMD;
      end
      S_CMD: begin
        if (seg_end) state_d = S_R1;
      end
      S_R1: begin
        if (seg_end) begin
          if (!rx_q[7]) begin
            state_d = (rx_q == 8'h00) ? S_TOKEN : S_FIN;
          end else if (r1_last) begin
            state_d = S_FIN;
          end
        end
      end
      S_TOKEN: begin
        if (seg_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (seg_end) state_d = S_CRC;
      end
      S_CRC: begin
        if (seg_end) state_d = S_DRESP;
      end
      S_DRESP: begin
        if (seg_end) begin
          state_d = (rx_q[4:0] == 5'b00101) ? S_BUSYW : S_FIN;
        end
      end
      S_BUSYW: begin
        if (seg_end) begin
          if (rx_q != 8'h00) begin
            state_d = S_FIN;
          end else if (bw_last) begin
            state_d = S_FIN;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    tx_load   = '1;
    bits_load = 6'd7;
    unique case (1'b1)
      (state_d == S_TOKEN): begin
        tx_load = {8'hFE, 40'hFF_FFFF_FFFF};
      end
      (state_d == S_DATA): begin
        tx_load   = {data_q, 32'hFFFF_FFFF};
        bits_load = 6'd15;
      end
      (state_d == S_CRC): begin
        bits_load = 6'd15;
      end
      default: begin
        tx_load = '1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      bit_left_q <= '0;
      poll_q     <= '0;
      tx_q       <= '1;
      rx_q       <= '0;
      data_q     <= '0;
      sclk_q     <= 1'b0;
      cs_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      cnt_q <= (!shifting || bit_end) ? '0 : cnt_q + CW'(1);

      if (rise) begin
        sclk_q <= 1'b1;
        rx_q   <= {rx_q[6:0], miso};
      end else if (bit_end) begin
        sclk_q <= 1'b0;
      end

      if (state_q == S_IDLE && start) begin
        busy_q     <= 1'b1;
        cs_q       <= 1'b0;
        data_q     <= data_in;
        tx_q       <= {8'h58, BLOCK_ADDR, 8'hFF};
        bit_left_q <= 6'd47;
        poll_q     <= '0;
      end

      if (state_q == S_FIN) begin
        busy_q <= 1'b0;
        cs_q   <= 1'b1;
      end

      if (bit_end && !seg_end) begin
        tx_q       <= {tx_q[46:0], 1'b1};
        bit_left_q <= bit_left_q - 6'd1;
      end

      // polled states reload in place and count their attempts
      if (seg_end) begin
        tx_q       <= tx_load;
        bit_left_q <= bits_load;
        poll_q     <= (state_d == state_q) ? poll_q + PW'(1) : '0;
      end
    end
  end

endmodule

// File: tb/tb_sd_spi_writer.sv
// Directed bench for sd_spi_writer with a bit-indexed SD card model
// on miso and a monitor that records mosi and sclk timing.
module tb_sd_spi_writer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] data_in;
  logic        busy;
  logic        sclk;
  logic        mosi;
  logic        miso;
  logic        cs;

  int checks = 0;
  int errors = 0;

  int           miso_mode = 0;
  logic [0:255] stream;
  logic [255:0] mosi_log;
  int           bitcnt;

  int cyc = 0;
  int hi_cnt = 0;
  int rises = 0;
  int iv = 0;
  int min_iv = 1000;
  int max_iv = 0;
  int bad_csbusy = 0;
  int bad_sclk = 0;
  logic cs_prev = 1'b1;
  logic sclk_prev = 1'b0;

  int t0;
  int dur;
  logic [7:0] resp;

  sd_spi_writer #(
    .CLK_DIV(4),
    .BLOCK_ADDR(32'h0),
    .R1_TIMEOUT(8),
    .BUSY_TIMEOUT(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .data_in(data_in),
    .busy(busy),
    .sclk(sclk),
    .mosi(mosi),
    .miso(miso),
    .cs(cs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign miso = (miso_mode == 0) ? 1'b0 :
                (miso_mode == 1) ? 1'b1 :
                (bitcnt < 256) ? stream[bitcnt] : 1'b1;

  always begin
    @(posedge sclk or negedge cs);
    if (sclk) begin
      mosi_log = {mosi_log[254:0], mosi};
      bitcnt   = bitcnt + 1;
    end else begin
      mosi_log = '0;
      bitcnt   = 0;
    end
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (cs == busy) bad_csbusy = bad_csbusy + 1;
    if (cs && sclk) bad_sclk = bad_sclk + 1;
    if (!cs && cs_prev) begin
      hi_cnt = 0;
      rises  = 0;
      iv     = 0;
      min_iv = 1000;
      max_iv = 0;
    end else if (!cs) begin
      iv = iv + 1;
      if (sclk && !sclk_prev) begin
        if (rises > 0) begin
          if (iv < min_iv) min_iv = iv;
          if (iv > max_iv) max_iv = iv;
        end
        rises = rises + 1;
        iv    = 0;
      end
      if (sclk) hi_cnt = hi_cnt + 1;
    end
    cs_prev   = cs;
    sclk_prev = sclk;
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [15:0] d);
    @(negedge clk);
    data_in = d;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    t0      = cyc;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 2000) begin
      @(posedge clk);
      #1;
      n = n + 1;
    end
    dur = cyc - t0;
    chk({tag, "_timeout"}, busy, 1'b0);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    data_in = 16'h0;
    stream  = '1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cs", cs, 1'b1);
    chk("rst_sclk", sclk, 1'b0);
    chk("rst_mosi", mosi, 1'b1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // miso stuck low: R1 ok, DRESP rejected
    miso_mode = 0;
    pulse_start(16'hAAAA);
    chk("a_busy_up", busy, 1'b1);
    chk("a_cs_low", cs, 1'b0);
    repeat (20) @(negedge clk);
    data_in = 16'h5555;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    wait_idle("a");
    chk("a_dur", dur, 417);
    chk("a_bits", bitcnt, 104);
    chk("a_mosi", mosi_log[103:0],
        {8'h58, 32'h0, 8'hFF, 8'hFF, 8'hFE, 16'hAAAA, 16'hFFFF, 8'hFF});
    chk("a_rises", rises, 104);
    chk("a_min_period", min_iv, 4);
    chk("a_max_period", max_iv, 4);
    chk("a_sclk_high", hi_cnt, 208);
    chk("a_cs_end", cs, 1'b1);
    chk("a_mosi_end", mosi, 1'b1);
    chk("a_sclk_end", sclk, 1'b0);
    repeat (3) @(negedge clk);
    chk("a_stay_idle", busy, 1'b0);

    // miso stuck high: R1 timeout after 8 bytes
    miso_mode = 1;
    pulse_start(16'h0F0F);
    wait_idle("c");
    chk("c_dur", dur, 449);
    chk("c_bits", bitcnt, 112);
    chk("c_cs_end", cs, 1'b1);
    chk("c_busy_end", busy, 1'b0);

    // asynchronous reset in the middle of a transfer
    miso_mode = 0;
    pulse_start(16'h1111);
    repeat (50) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("d_busy", busy, 1'b0);
    chk("d_cs", cs, 1'b1);
    chk("d_sclk", sclk, 1'b0);
    chk("d_mosi", mosi, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // card model: R1=00, DRESP=E5, three busy bytes then FF
    stream = '1;
    for (int i = 0; i < 8; i++) stream[48+i] = 1'b0;
    resp = 8'hE5;
    for (int i = 0; i < 8; i++) stream[96+i] = resp[7-i];
    for (int i = 0; i < 24; i++) stream[104+i] = 1'b0;
    miso_mode = 2;
    pulse_start(16'h1234);
    wait_idle("b");
    chk("b_dur", dur, 545);
    chk("b_bits", bitcnt, 136);
    chk("b_mosi_head", mosi_log[135:88], {8'h58, 32'h0, 8'hFF});
    chk("b_mosi_tail", mosi_log[87:0],
        {8'hFF, 8'hFE, 16'h1234, 16'hFFFF, 8'hFF, 32'hFFFF_FFFF});
    chk("b_cs_end", cs, 1'b1);

    chk("cs_busy_inverse", bad_csbusy, 0);
    chk("sclk_only_cs_low", bad_sclk, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
